// File: rtl/jtkcpu_stack.sv
// Stack push/pull sequencer: turns one microcode stack request into a byte-serial
// run of bus cycles on the selected stack pointer, loading pulled bytes into the register file.
module jtkcpu_stack #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          psh_go,
  input  logic          pul_go,
  input  logic          psh_all,
  input  logic          psh_cc,
  input  logic          psh_pc,
  input  logic          pul_pc,
  input  logic          rti_cc,
  input  logic          rti_other,
  input  logic          use_u,
  input  logic [7:0]    postbyte,
  input  logic [7:0]    cc,
  input  logic [7:0]    a,
  input  logic [7:0]    b,
  input  logic [7:0]    dp,
  input  logic [AW-1:0] x,
  input  logic [AW-1:0] y,
  input  logic [AW-1:0] other_sp,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] sp_in,
  input  logic [7:0]    din,
  input  logic          mem_busy,
  output logic [AW-1:0] addr,
  output logic [7:0]    dout,
  output logic          we,
  output logic          rd,
  output logic [AW-1:0] sp_out,
  output logic          sp_we,
  output logic          ld_en,
  output logic [2:0]    ld_sel,
  output logic          ld_hi,
  output logic [7:0]    ld_data,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, PUSH, PULL, FIN} state_t;

  state_t        state, state_d;
  logic [7:0]    mask, mask_d;
  logic [AW-1:0] ptr, ptr_d;
  logic          second, second_d;

  logic [7:0]    start_mask, rest_mask;
  logic [2:0]    idx;
  logic          wide, byte_hi, go;
  logic [15:0]   reg16;
  logic [7:0]    cur_byte;

  // S/U selection happens upstream, where sp_in and other_sp are already muxed
  logic unused_use_u;
  assign unused_use_u = use_u;

  function automatic logic [2:0] top_bit(input logic [7:0] m);
    top_bit = 3'd0;
    for (int i = 0; i < 8; i++)
      if (m[i]) top_bit = 3'(i);
  endfunction

  function automatic logic [2:0] bottom_bit(input logic [7:0] m);
    bottom_bit = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (m[i]) bottom_bit = 3'(i);
  endfunction

  assign go = psh_go | pul_go;

  always_comb begin
    start_mask = postbyte;
    if (psh_go) begin
      if (psh_all)     start_mask = 8'hFF;
      else if (psh_pc) start_mask = 8'h80;
      else if (psh_cc) start_mask = 8'h01;
    end else begin
      if (pul_pc)         start_mask = 8'h80;
      else if (rti_cc)    start_mask = 8'h01;
      else if (rti_other) start_mask = 8'hFE;
    end
  end

  // Push walks the mask from PC down, pull from CC up; 16-bit regs occupy bits 4..7
  assign idx       = (state == PUSH) ? top_bit(mask) : bottom_bit(mask);
  assign wide      = idx[2];
  assign byte_hi   = wide & ((state == PUSH) ? second : ~second);
  assign rest_mask = mask & ~(8'd1 << idx);

  always_comb begin
    case (idx[1:0])
      2'd0:    reg16 = x[15:0];
      2'd1:    reg16 = y[15:0];
      2'd2:    reg16 = other_sp[15:0];
      default: reg16 = pc[15:0];
    endcase
    if (wide)
      cur_byte = byte_hi ? reg16[15:8] : reg16[7:0];
    else begin
      case (idx[1:0])
        2'd0:    cur_byte = cc;
        2'd1:    cur_byte = a;
        2'd2:    cur_byte = b;
        default: cur_byte = dp;
      endcase
    end
  end

  always_comb begin
    state_d  = state;
    mask_d   = mask;
    ptr_d    = ptr;
    second_d = second;
    case (state)
      IDLE: if (go) begin
        mask_d   = start_mask;
        ptr_d    = sp_in;
        second_d = 1'b0;
        if (start_mask == 8'd0) state_d = FIN;
        else                    state_d = psh_go ? PUSH : PULL;
      end
      PUSH, PULL: if (!mem_busy) begin
        ptr_d = (state == PUSH) ? ptr - AW'(1) : ptr + AW'(1);
        if (wide && !second) begin
          second_d = 1'b1;
        end else begin
          second_d = 1'b0;
          mask_d   = rest_mask;
          if (rest_mask == 8'd0) state_d = FIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mask   <= 8'd0;
      ptr    <= '0;
      second <= 1'b0;
    end else if (cen) begin
      state  <= state_d;
      mask   <= mask_d;
      ptr    <= ptr_d;
      second <= second_d;
    end
  end

  // Bus strobes are levels held through mem_busy; load/done strobes count once per cen
  always_comb begin
    busy    = (state != IDLE);
    done    = (state == FIN) & cen;
    sp_we   = (state == FIN) & cen;
    sp_out  = ptr;
    we      = (state == PUSH);
    rd      = (state == PULL);
    addr    = '0;
    dout    = 8'd0;
    ld_en   = 1'b0;
    ld_sel  = 3'd0;
    ld_hi   = 1'b0;
    ld_data = 8'd0;
    if (state == PUSH) begin
      addr = ptr - AW'(1);
      dout = cur_byte;
    end
    if (state == PULL) begin
      addr = ptr;
      if (cen && !mem_busy) begin
        ld_en   = 1'b1;
        ld_sel  = idx;
        ld_hi   = byte_hi;
        ld_data = din;
      end
    end
  end

endmodule

// File: tb/tb_jtkcpu_stack.sv
// Directed bench for jtkcpu_stack: logs bus writes, register loads and done pulses
// and compares them against hand-computed sequences.
module tb_jtkcpu_stack;

  logic        clk = 1'b0;
  logic        rst_n, cen, psh_go, pul_go, psh_all, psh_cc, psh_pc;
  logic        pul_pc, rti_cc, rti_other, use_u, mem_busy;
  logic [7:0]  postbyte, cc, a, b, dp, din, dout, ld_data;
  logic [15:0] x, y, other_sp, pc, sp_in, addr, sp_out;
  logic        we, rd, sp_we, ld_en, ld_hi, busy, done;
  logic [2:0]  ld_sel;

  logic [7:0]  mem [0:65535];
  logic [23:0] wq[$];
  logic [11:0] lq[$];
  int          n_done, clash, n_vec, n_err, cnt;
  logic [15:0] last_sp;

  always #5 clk = ~clk;

  jtkcpu_stack #(.AW(16)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .psh_go(psh_go), .pul_go(pul_go),
    .psh_all(psh_all), .psh_cc(psh_cc), .psh_pc(psh_pc), .pul_pc(pul_pc),
    .rti_cc(rti_cc), .rti_other(rti_other), .use_u(use_u), .postbyte(postbyte),
    .cc(cc), .a(a), .b(b), .dp(dp), .x(x), .y(y), .other_sp(other_sp), .pc(pc),
    .sp_in(sp_in), .din(din), .mem_busy(mem_busy), .addr(addr), .dout(dout),
    .we(we), .rd(rd), .sp_out(sp_out), .sp_we(sp_we), .ld_en(ld_en),
    .ld_sel(ld_sel), .ld_hi(ld_hi), .ld_data(ld_data), .busy(busy), .done(done)
  );

  assign din = rd ? mem[addr] : 8'h00;

  always @(negedge clk) begin
    if (cen && we && !mem_busy) wq.push_back({addr, dout});
    if (ld_en) lq.push_back({ld_sel, ld_hi, ld_data});
    if (done) begin
      n_done++;
      last_sp = sp_out;
    end
    if (we && rd) clash++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wq.delete();
    lq.delete();
    n_done  = 0;
    last_sp = 16'hDEAD;
  endtask

  task automatic go(input logic push, input logic pull);
    psh_go = push;
    pul_go = pull;
    tick();
    psh_go = 1'b0;
    pul_go = 1'b0;
    {psh_all, psh_cc, psh_pc, pul_pc, rti_cc, rti_other} = '0;
  endtask

  task automatic wait_idle(input int budget, output int n);
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    if (busy) chk("timeout", 32'(busy), 32'd0);
  endtask

  logic [23:0] exp_all [12];
  logic [23:0] w;
  logic [11:0] l;

  initial begin
    n_vec = 0; n_err = 0; clash = 0;
    rst_n = 1'b0; cen = 1'b1; mem_busy = 1'b0; use_u = 1'b0;
    psh_go = 0; pul_go = 0;
    {psh_all, psh_cc, psh_pc, pul_pc, rti_cc, rti_other} = '0;
    postbyte = 8'h00; cc = 8'h80; a = 8'h11; b = 8'h22; dp = 8'h33;
    x = 16'h4455; y = 16'h6677; other_sp = 16'h8899; pc = 16'h1234;
    sp_in = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h2000] = 8'hAA; mem[16'h2001] = 8'hBB;
    mem[16'h0FFF] = 8'h12; mem[16'h0000] = 8'h34;
    exp_all = '{24'h0FFF34, 24'h0FFE12, 24'h0FFD99, 24'h0FFC88, 24'h0FFB77, 24'h0FFA66,
                24'h0FF955, 24'h0FF844, 24'h0FF733, 24'h0FF622, 24'h0FF511, 24'h0FF480};
    clear_logs();
    tick(); tick();
    chk("rst_outs", 32'({busy, done, we, rd, sp_we, ld_en}), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    rst_n = 1'b1;
    tick();

    // Full interrupt frame
    clear_logs();
    sp_in = 16'h1000; psh_all = 1'b1;
    go(1'b1, 1'b0);
    wait_idle(40, cnt);
    chk("all_lat", 32'(cnt), 32'd13);
    chk("all_nwr", 32'(wq.size()), 32'd12);
    for (int i = 0; i < 12; i++) begin
      w = (i < wq.size()) ? wq[i] : 24'h0;
      chk($sformatf("all_wr%0d", i), 32'(w), 32'(exp_all[i]));
    end
    chk("all_sp", 32'(last_sp), 32'h0FF4);
    chk("all_done", 32'(n_done), 32'd1);

    // Pull A and B via postbyte
    clear_logs();
    sp_in = 16'h2000; postbyte = 8'h06;
    go(1'b0, 1'b1);
    wait_idle(20, cnt);
    chk("ab_nld", 32'(lq.size()), 32'd2);
    l = (lq.size() > 0) ? lq[0] : 12'h0; chk("ab_ld0", 32'(l), 32'({3'd1, 1'b0, 8'hAA}));
    l = (lq.size() > 1) ? lq[1] : 12'h0; chk("ab_ld1", 32'(l), 32'({3'd2, 1'b0, 8'hBB}));
    chk("ab_sp", 32'(last_sp), 32'h2002);

    // Pull PC across the address wrap
    clear_logs();
    sp_in = 16'h0FFF; postbyte = 8'h00; pul_pc = 1'b1;
    mem[16'h0FFF] = 8'h12; mem[16'h1000] = 8'h34;
    go(1'b0, 1'b1);
    wait_idle(20, cnt);
    l = (lq.size() > 0) ? lq[0] : 12'h0; chk("pc_ld0", 32'(l), 32'({3'd7, 1'b1, 8'h12}));
    l = (lq.size() > 1) ? lq[1] : 12'h0; chk("pc_ld1", 32'(l), 32'({3'd7, 1'b0, 8'h34}));
    chk("pc_sp", 32'(last_sp), 32'h1001);
    clear_logs();
    sp_in = 16'hFFFF; pul_pc = 1'b1;
    mem[16'hFFFF] = 8'h12; mem[16'h0000] = 8'h34;
    go(1'b0, 1'b1);
    wait_idle(20, cnt);
    l = (lq.size() > 1) ? lq[1] : 12'h0; chk("wrap_ld1", 32'(l), 32'({3'd7, 1'b0, 8'h34}));
    chk("wrap_sp", 32'(last_sp), 32'h0001);

    // Empty mask
    clear_logs();
    sp_in = 16'h3456; postbyte = 8'h00;
    go(1'b1, 1'b0);
    chk("nil_busy", 32'(busy), 32'd1);
    chk("nil_done", 32'(done), 32'd1);
    wait_idle(10, cnt);
    chk("nil_lat", 32'(cnt), 32'd1);
    chk("nil_nwr", 32'(wq.size()), 32'd0);
    chk("nil_sp", 32'(last_sp), 32'h3456);

    // Push X with bus wait on the first byte
    clear_logs();
    sp_in = 16'h4000; postbyte = 8'h10; x = 16'hBEEF;
    go(1'b1, 1'b0);
    mem_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("hold_bus%0d", k), 32'({addr, dout, we}), 32'({16'h3FFF, 8'hEF, 1'b1}));
      tick();
    end
    mem_busy = 1'b0;
    wait_idle(20, cnt);
    chk("hold_nwr", 32'(wq.size()), 32'd2);
    w = (wq.size() > 0) ? wq[0] : 24'h0; chk("hold_wr0", 32'(w), 32'h3FFFEF);
    w = (wq.size() > 1) ? wq[1] : 24'h0; chk("hold_wr1", 32'(w), 32'h3FFEBE);
    chk("hold_sp", 32'(last_sp), 32'h3FFE);

    // Same push with cen toggling
    clear_logs();
    go(1'b1, 1'b0);
    cnt = 0;
    while (busy && cnt < 40) begin
      cen = 1'b0; tick();
      cen = 1'b1; tick();
      cnt++;
    end
    chk("cen_idle", 32'(busy), 32'd0);
    chk("cen_nwr", 32'(wq.size()), 32'd2);
    w = (wq.size() > 0) ? wq[0] : 24'h0; chk("cen_wr0", 32'(w), 32'h3FFFEF);
    w = (wq.size() > 1) ? wq[1] : 24'h0; chk("cen_wr1", 32'(w), 32'h3FFEBE);
    chk("cen_done", 32'(n_done), 32'd1);

    // Simultaneous push and pull requests
    clear_logs();
    sp_in = 16'h5000; cc = 8'h5A; psh_cc = 1'b1; pul_pc = 1'b1;
    go(1'b1, 1'b1);
    wait_idle(20, cnt);
    chk("both_nwr", 32'(wq.size()), 32'd1);
    w = (wq.size() > 0) ? wq[0] : 24'h0; chk("both_wr", 32'(w), 32'h4FFF5A);
    chk("both_nld", 32'(lq.size()), 32'd0);
    chk("both_sp", 32'(last_sp), 32'h4FFF);

    // Reset in the middle of a full frame
    clear_logs();
    sp_in = 16'h1000; cc = 8'h80; x = 16'h4455; psh_all = 1'b1;
    go(1'b1, 1'b0);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid", 32'({busy, we, done}), 32'd0);
    tick(); tick();
    chk("rst_nwr", 32'(wq.size()), 32'd2);
    chk("rst_nodone", 32'(n_done), 32'd0);
    rst_n = 1'b1;
    tick();
    clear_logs();
    sp_in = 16'h2000; rti_cc = 1'b1;
    go(1'b0, 1'b1);
    wait_idle(20, cnt);
    chk("post_nld", 32'(lq.size()), 32'd1);
    l = (lq.size() > 0) ? lq[0] : 12'h0; chk("post_ld", 32'(l), 32'({3'd0, 1'b0, 8'hAA}));
    chk("post_sp", 32'(last_sp), 32'h2001);
    chk("post_done", 32'(n_done), 32'd1);
    chk("we_rd_clash", 32'(clash), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
